// File: rtl/gray_seq_pkg.sv
// Shared types and helpers for the Gray-code sequencer.
package gray_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } gray_seq_state_t;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/bin2gray_n.sv
// Combinational binary-to-Gray converter of arbitrary width.
module bin2gray_n #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] bin_i,
  output logic [WIDTH-1:0] gray_o
);

  assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/gray_seq_ctrl.sv
// Emits a run of binary/Gray code pairs over a valid/ready stream,
// stepping up or down modulo 2**WIDTH from a commanded start value.
module gray_seq_ctrl
  import gray_seq_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             dir,
  input  logic [WIDTH-1:0] start_val,
  input  logic [WIDTH:0]   len,
  input  logic             abort,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] gray_out,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH:0] REM_ONE = {{WIDTH{1'b0}}, 1'b1};

  gray_seq_state_t state_q, state_d;
  logic [WIDTH:0]   remaining_q, remaining_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Gray is derived from the next binary value so both land in the same register edge.
  bin2gray_n #(.WIDTH(WIDTH)) u_bin2gray (
    .bin_i  (bin_d),
    .gray_o (gray_d)
  );

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    dir_d       = dir_q;
    bin_d       = bin_q;
    valid_d     = valid_q;

    unique case (state_q)
      IDLE: begin
        if (start && (len != '0)) begin
          state_d     = RUN;
          bin_d       = start_val;
          valid_d     = 1'b1;
          remaining_d = len;
          dir_d       = dir;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end else if (valid_q && out_ready) begin
          if (remaining_q > REM_ONE) begin
            remaining_d = remaining_q - REM_ONE;
            bin_d       = (dir_q == DIR_DN) ? (bin_q - 1'b1) : (bin_q + 1'b1);
          end else begin
            state_d     = DONE;
            valid_d     = 1'b0;
            remaining_d = '0;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      dir_q       <= DIR_UP;
      bin_q       <= '0;
      gray_q      <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      dir_q       <= dir_d;
      bin_q       <= bin_d;
      gray_q      <= gray_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign out_valid = valid_q;
  assign bin_out   = bin_q;
  assign gray_out  = gray_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// Directed self-checking bench for gray_seq_ctrl at WIDTH=3.
module tb_gray_seq_ctrl;

  localparam int W = 3;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         dir;
  logic [W-1:0] start_val;
  logic [W:0]   len;
  logic         abort;
  logic         out_ready;
  logic         out_valid;
  logic [W-1:0] bin_out;
  logic [W-1:0] gray_out;
  logic         busy;
  logic         done;

  int compared   = 0;
  int mismatched = 0;

  gray_seq_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .dir       (dir),
    .start_val (start_val),
    .len       (len),
    .abort     (abort),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .bin_out   (bin_out),
    .gray_out  (gray_out),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulses start for one edge; returns at the negedge where the first beat is visible.
  task automatic do_start(input logic [W-1:0] sv, input logic [W:0] n, input logic d);
    start_val = sv;
    len       = n;
    dir       = d;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    compared++;
    if ({out_valid, busy, done, bin_out, gray_out} !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset_init: got v=%b b=%b d=%b bin=%0d gray=%0d, want all 0",
               out_valid, busy, done, bin_out, gray_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    out_ready = 1'b1;
    do_start(3'd2, 4'd8, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    compared++;
    if ({out_valid, busy, done, bin_out, gray_out} !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset_async: got v=%b b=%b d=%b bin=%0d gray=%0d, want all 0",
               out_valid, busy, done, bin_out, gray_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_start(3'd0, 4'd1, 1'b0);
    compared++;
    if (!(out_valid === 1'b1 && bin_out === 3'd0 && gray_out === 3'd0 && busy === 1'b1 && done === 1'b0)) begin
      mismatched++;
      $display("[TB] FAIL reset_single_beat: got v=%b bin=%0d gray=%0d busy=%b done=%b, want 1/0/0/1/0",
               out_valid, bin_out, gray_out, busy, done);
    end
    @(negedge clk);
    compared++;
    if (!(done === 1'b1 && out_valid === 1'b0)) begin
      mismatched++;
      $display("[TB] FAIL reset_single_done: got done=%b v=%b, want 1/0", done, out_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_full_sweep();
    logic [W-1:0] expGray [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
    out_ready = 1'b1;
    do_start(3'd0, 4'd8, 1'b0);
    for (int i = 0; i < 8; i++) begin
      compared++;
      if (!(out_valid === 1'b1 && gray_out === expGray[i] && bin_out === 3'(i))) begin
        mismatched++;
        $display("[TB] FAIL sweep_beat%0d: got v=%b bin=%0d gray=%b, want 1/%0d/%b",
                 i, out_valid, bin_out, gray_out, i, expGray[i]);
      end
      @(negedge clk);
    end
    compared++;
    if (!(done === 1'b1 && out_valid === 1'b0 && busy === 1'b1)) begin
      mismatched++;
      $display("[TB] FAIL sweep_done: got done=%b v=%b busy=%b, want 1/0/1", done, out_valid, busy);
    end
    @(negedge clk);
    compared++;
    if (!(done === 1'b0 && busy === 1'b0)) begin
      mismatched++;
      $display("[TB] FAIL sweep_idle: got done=%b busy=%b, want 0/0", done, busy);
    end
  endtask

  task automatic test_wrap_dir();
    logic [W-1:0] upBin  [4] = '{3'd6, 3'd7, 3'd0, 3'd1};
    logic [W-1:0] upGray [4] = '{3'b101, 3'b100, 3'b000, 3'b001};
    logic [W-1:0] dnBin  [3] = '{3'd1, 3'd0, 3'd7};
    logic [W-1:0] dnGray [3] = '{3'b001, 3'b000, 3'b100};
    out_ready = 1'b1;
    do_start(3'd6, 4'd4, 1'b0);
    for (int i = 0; i < 4; i++) begin
      compared++;
      if (!(out_valid === 1'b1 && bin_out === upBin[i] && gray_out === upGray[i])) begin
        mismatched++;
        $display("[TB] FAIL wrap_up%0d: got v=%b bin=%0d gray=%b, want 1/%0d/%b",
                 i, out_valid, bin_out, gray_out, upBin[i], upGray[i]);
      end
      @(negedge clk);
    end
    @(negedge clk);
    do_start(3'd1, 4'd3, 1'b1);
    for (int i = 0; i < 3; i++) begin
      compared++;
      if (!(out_valid === 1'b1 && bin_out === dnBin[i] && gray_out === dnGray[i])) begin
        mismatched++;
        $display("[TB] FAIL wrap_dn%0d: got v=%b bin=%0d gray=%b, want 1/%0d/%b",
                 i, out_valid, bin_out, gray_out, dnBin[i], dnGray[i]);
      end
      @(negedge clk);
    end
    compared++;
    if (done !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL wrap_dn_done: got done=%b, want 1", done);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic readyPat [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [W-1:0] seen [$];
    int xfers = 0;
    int doneAt = -1;
    do_start(3'd0, 4'd4, 1'b0);
    for (int k = 0; k < 20; k++) begin
      if (done === 1'b1) begin
        doneAt = xfers;
        break;
      end
      out_ready = (k < 8) ? readyPat[k] : 1'b1;
      if (k >= 1 && k <= 3) begin
        compared++;
        if (!(out_valid === 1'b1 && bin_out === 3'd1 && gray_out === 3'b001)) begin
          mismatched++;
          $display("[TB] FAIL bp_hold%0d: got v=%b bin=%0d gray=%b, want 1/1/001",
                   k, out_valid, bin_out, gray_out);
        end
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        seen.push_back(bin_out);
        xfers++;
      end
      @(negedge clk);
    end
    compared++;
    if (!(xfers == 4 && doneAt == 4)) begin
      mismatched++;
      $display("[TB] FAIL bp_count: got transfers=%0d doneAfter=%0d, want 4/4", xfers, doneAt);
    end
    for (int i = 0; i < seen.size() && i < 4; i++) begin
      compared++;
      if (seen[i] !== 3'(i)) begin
        mismatched++;
        $display("[TB] FAIL bp_seq%0d: got bin=%0d, want %0d", i, seen[i], i);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_abort();
    out_ready = 1'b1;
    do_start(3'd2, 4'd8, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    compared++;
    if (bin_out !== 3'd5) begin
      mismatched++;
      $display("[TB] FAIL abort_pre: got bin=%0d, want 5", bin_out);
    end
    abort     = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    abort     = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      compared++;
      if (!(out_valid === 1'b0 && busy === 1'b0 && done === 1'b0)) begin
        mismatched++;
        $display("[TB] FAIL abort_idle%0d: got v=%b busy=%b done=%b, want 0/0/0",
                 k, out_valid, busy, done);
      end
      @(negedge clk);
    end
    do_start(3'd5, 4'd2, 1'b1);
    compared++;
    if (!(out_valid === 1'b1 && bin_out === 3'd5 && gray_out === 3'b111)) begin
      mismatched++;
      $display("[TB] FAIL abort_restart0: got v=%b bin=%0d gray=%b, want 1/5/111", out_valid, bin_out, gray_out);
    end
    @(negedge clk);
    compared++;
    if (!(out_valid === 1'b1 && bin_out === 3'd4 && gray_out === 3'b110)) begin
      mismatched++;
      $display("[TB] FAIL abort_restart1: got v=%b bin=%0d gray=%b, want 1/4/110", out_valid, bin_out, gray_out);
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_ignored();
    out_ready = 1'b1;
    do_start(3'd3, 4'd0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      compared++;
      if (!(out_valid === 1'b0 && done === 1'b0 && busy === 1'b0)) begin
        mismatched++;
        $display("[TB] FAIL len0_%0d: got v=%b done=%b busy=%b, want 0/0/0", k, out_valid, done, busy);
      end
      @(negedge clk);
    end
    do_start(3'd0, 4'd4, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        start_val = 3'd6;
        len       = 4'd2;
        start     = 1'b1;
      end else begin
        start = 1'b0;
      end
      compared++;
      if (!(out_valid === 1'b1 && bin_out === 3'(i))) begin
        mismatched++;
        $display("[TB] FAIL busy_start%0d: got v=%b bin=%0d, want 1/%0d", i, out_valid, bin_out, i);
      end
      @(negedge clk);
    end
    start = 1'b0;
    compared++;
    if (done !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL busy_start_done: got done=%b, want 1", done);
    end
    @(negedge clk);
    abort = 1'b1;
    do_start(3'd3, 4'd1, 1'b0);
    abort = 1'b0;
    compared++;
    if (!(out_valid === 1'b1 && bin_out === 3'd3 && gray_out === 3'b010)) begin
      mismatched++;
      $display("[TB] FAIL start_abort: got v=%b bin=%0d gray=%b, want 1/3/010", out_valid, bin_out, gray_out);
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    start     = 1'b0;
    dir       = 1'b0;
    start_val = '0;
    len       = '0;
    abort     = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_full_sweep();
    test_wrap_dir();
    test_backpressure();
    test_abort();
    test_ignored();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
